// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and helpers for the seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package hex_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic {
        PH_GUARD,
        PH_DRIVE
    } slot_phase_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank_lz;
    } shadow_t;

    localparam logic [7:0] SEG_OFF  = 8'hFF;
    localparam logic [3:0] GRID_OFF = 4'hF;
    localparam logic [7:0] SEG_DP_ONLY = 8'h7F;

    // Element 15 first: SEG_LUT[n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [3:0] grid_onehot_n(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex_scan_driver_if.sv
// Data-source / display-pin bundle for the scan driver.
// The source side (master) supplies display data; the driver (slave) returns pin values.
interface hex_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic        en;
    logic [7:0]  hex_seg;
    logic [3:0]  hex_grid;
    logic        frame_start;

    modport master (output value, dp_in, blank_lz, en,
                    input  hex_seg, hex_grid, frame_start);
    modport slave  (input  value, dp_in, blank_lz, en,
                    output hex_seg, hex_grid, frame_start);
endinterface

// File: rtl/hex_scan_driver_seg_encode.sv
// Hex nibble to active-low seven-segment pattern.
module hex_seg_encode
    import hex_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);
    assign seg_n = SEG_LUT[nib];
endmodule

// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed seven-segment driver with per-slot guard time,
// frame-synchronous data latching and optional leading-zero blanking.
module hex_scan_driver
    import hex_pkg::*;
#(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic          Clk,
    input  logic          Reset_n,
    hex_scan_driver_if.slave bus
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    shadow_t          shadow_q, shadow_d;
    logic             load_pending_q, load_pending_d;
    logic [3:0]       grid_q, grid_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic             wrap;
    slot_phase_t      phase_d;
    logic [3:0]       cur_nib;
    logic [6:0]       enc_seg;
    logic [3:0]       hi_zero;
    logic             blank, dp_cur;

    always_comb begin
        wrap           = (cnt_q == CNT_W'(DIV - 1));
        cnt_d          = wrap ? '0 : cnt_q + 1'b1;
        idx_d          = wrap ? idx_q + 2'd1 : idx_q;
        load_pending_d = 1'b0;
        shadow_d       = shadow_q;
        // Latch only at the frame boundary so a frame is never torn.
        if (load_pending_q || (wrap && idx_q == 2'd3))
            shadow_d = '{value: bus.value, dp: bus.dp_in, blank_lz: bus.blank_lz};
    end

    // hi_zero[i]: nibbles i..3 of the frame being shown are all zero.
    always_comb begin
        hi_zero    = '0;
        hi_zero[3] = (shadow_d.value[15:12] == 4'h0);
        for (int i = 2; i >= 0; i--)
            hi_zero[i] = hi_zero[i+1] && (shadow_d.value[4*i +: 4] == 4'h0);
    end

    assign cur_nib = shadow_d.value[{idx_d, 2'b00} +: 4];

    hex_seg_encode u_enc (
        .nib  (cur_nib),
        .seg_n(enc_seg)
    );

    // Outputs are computed from next-state so they line up with (idx, cnt).
    always_comb begin
        phase_d       = (int'(cnt_d) >= BLANK_CYC) ? PH_DRIVE : PH_GUARD;
        blank         = shadow_d.blank_lz && (idx_d != 2'd0) && hi_zero[idx_d];
        dp_cur        = shadow_d.dp[idx_d];
        frame_start_d = (idx_d == 2'd0) && (cnt_d == '0);
        grid_d        = GRID_OFF;
        seg_d         = SEG_OFF;
        if (bus.en && phase_d == PH_DRIVE) begin
            if (!blank) begin
                grid_d = grid_onehot_n(idx_d);
                seg_d  = {~dp_cur, enc_seg};
            end else if (dp_cur) begin
                grid_d = grid_onehot_n(idx_d);
                seg_d  = SEG_DP_ONLY;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            load_pending_q <= 1'b1;
            grid_q         <= GRID_OFF;
            seg_q          <= SEG_OFF;
            frame_start_q  <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            load_pending_q <= load_pending_d;
            grid_q         <= grid_d;
            seg_q          <= seg_d;
            frame_start_q  <= frame_start_d;
        end
    end

    assign bus.hex_grid    = grid_q;
    assign bus.hex_seg     = seg_q;
    assign bus.frame_start = frame_start_q;

endmodule
